// File: rtl/reset_seq_ctrl.sv
// reset_seq_ctrl: sequences N_DOM active-low domain resets in ascending order.
// Latency: bit 0 releases HOLD counting edges after the last reset/soft edge;
//          each following bit releases GAP edges after the previous one.
// Backpressure: none. A soft reset (or loss of lock) restarts the whole sequence.
//
// Ports:
//   sys_clk     sole clock, rising edge
//   rst_n       asynchronous active-low reset (synchronized internally for release)
//   i_soft_rst  synchronous level soft-reset request, active-high
//   i_locked    (only with RST_SEQ_LOCK_EN) async clock-lock qualifier
//   o_rst_n     per-domain active-low resets, bit 0 released first
//   o_stage     number of domains currently released
//   o_done      high once every domain is released
//
// Optional feature: define RST_SEQ_LOCK_EN to add the i_locked qualifier.

module reset_seq_ctrl #(
  parameter int N_DOM = 4,
  parameter int HOLD  = 8,
  parameter int GAP   = 16
) (
  input  logic             sys_clk,
  input  logic             rst_n,
`ifdef RST_SEQ_LOCK_EN
  input  logic             i_locked,
`endif
  input  logic             i_soft_rst,
  output logic [N_DOM-1:0] o_rst_n,
  output logic [3:0]       o_stage,
  output logic             o_done
);

  localparam logic [7:0] HOLD_CNT = 8'(HOLD);
  localparam logic [7:0] GAP_CNT  = 8'(GAP);
  localparam logic [3:0] LAST_IDX = 4'(N_DOM - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Reset synchronizer: asserts with rst_n, releases on the 2nd edge after it rises.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  logic lock_ok;

`ifdef RST_SEQ_LOCK_EN
  logic [1:0] lock_sync_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_q <= 2'b00;
    end else begin
      lock_sync_q <= {lock_sync_q[0], i_locked};
    end
  end

  assign lock_ok = lock_sync_q[1];
`else
  assign lock_ok = 1'b1;
`endif

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [N_DOM-1:0] rst_vec_q, rst_vec_d;
  logic [3:0]       stage_q, stage_d;
  logic             done_q, done_d;

  logic restart;
  logic elapsed;
  logic step;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_vec_d = rst_vec_q;
    stage_d   = stage_q;
    done_d    = done_q;

    // Lost lock only matters once we have started releasing; in ASSERT it
    // merely blocks the exit.
    restart = !rst_int_n || i_soft_rst || (!lock_ok && (state_q != ST_ASSERT));
    // Counter reaching 1 on a counting edge means HOLD/GAP edges have elapsed
    // on this edge; 0 only occurs while waiting for lock after HOLD expired.
    elapsed = (cnt_q <= 8'd1);
    step    = 1'b0;

    if (restart) begin
      state_d   = ST_ASSERT;
      cnt_d     = HOLD_CNT;
      rst_vec_d = '0;
      stage_d   = 4'd0;
      done_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          if (elapsed && lock_ok) begin
            step = 1'b1;
          end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        ST_RELEASE: begin
          if (elapsed) begin
            step = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: begin
          // ST_DONE holds until a restart cause appears.
        end
      endcase

      if (step) begin
        // Exactly one new bit per step: the one indexed by the current stage.
        for (int i = 0; i < N_DOM; i++) begin
          if (4'(i) == stage_q) begin
            rst_vec_d[i] = 1'b1;
          end
        end
        stage_d = stage_q + 4'd1;
        if (stage_q == LAST_IDX) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RELEASE;
          cnt_d   = GAP_CNT;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= HOLD_CNT;
      rst_vec_q <= '0;
      stage_q   <= 4'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_vec_q <= rst_vec_d;
      stage_q   <= stage_d;
      done_q    <= done_d;
    end
  end

  assign o_rst_n = rst_vec_q;
  assign o_stage = stage_q;
  assign o_done  = done_q;

endmodule
